// File: rtl/program_loader.sv
// Byte-stream loader for the 8-bit core's instruction RAM.
// Optional zero-fill, sequential load from address 0, then PC restart and CPU release.
module program_loader #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int DEPTH    = 256,
  parameter int CLEAR_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              byte_valid,
  input  logic [DATA_W-1:0] byte_data,
  input  logic              byte_last,
  output logic              byte_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              pc_recount,
  output logic              cpu_hold,
  output logic              load_done,
  output logic [ADDR_W:0]   byte_count,
  output logic              overflow_err
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD,
    FINISH,
    RUN
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              pc_q;
  logic              hold_q;
  logic              done_q;
  logic [ADDR_W:0]   bc_q;
  logic              ovf_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      pc_q    <= 1'b0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      bc_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      we_q <= 1'b0;
      pc_q <= 1'b0;
      unique case (state_q)
        IDLE, RUN: begin
          if (state_q == RUN) hold_q <= 1'b0;
          if (load_start) begin
            cnt_q   <= '0;
            bc_q    <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            hold_q  <= 1'b1;
            state_q <= (CLEAR_EN != 0) ? CLEAR : LOAD;
          end
        end
        CLEAR: begin
          we_q   <= 1'b1;
          addr_q <= cnt_q;
          data_q <= '0;
          if (cnt_q == LAST) begin
            cnt_q   <= '0;
            state_q <= LOAD;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        LOAD: begin
          if (byte_valid) begin
            we_q   <= 1'b1;
            addr_q <= cnt_q;
            data_q <= byte_data;
            cnt_q  <= cnt_q + 1'b1;
            bc_q   <= bc_q + 1'b1;
            // byte_last wins over a full RAM
            if (byte_last) begin
              state_q <= FINISH;
            end else if (cnt_q == LAST) begin
              ovf_q   <= 1'b1;
              state_q <= FINISH;
            end
          end
        end
        FINISH: begin
          pc_q    <= 1'b1;
          done_q  <= 1'b1;
          state_q <= RUN;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign byte_ready   = (state_q == LOAD);
  assign ram_we       = we_q;
  assign ram_addr     = addr_q;
  assign ram_data     = data_q;
  assign pc_recount   = pc_q;
  assign cpu_hold     = hold_q;
  assign load_done    = done_q;
  assign byte_count   = bc_q;
  assign overflow_err = ovf_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: two DEPTH=16 instances, one without and one with zero-fill.
// Observed RAM writes are logged and compared against the byte stream that was sent.
module tb_program_loader;

  logic       clk;
  logic       rst;
  logic       ls   [2];
  logic       bv   [2];
  logic       bl   [2];
  logic [7:0] bd   [2];
  logic       rdy  [2];
  logic       we   [2];
  logic [3:0] addr [2];
  logic [7:0] data [2];
  logic       pc   [2];
  logic       hold [2];
  logic       done [2];
  logic [4:0] bc   [2];
  logic       ovf  [2];

  program_loader #(.DATA_W(8), .ADDR_W(4), .DEPTH(16), .CLEAR_EN(0)) u0 (
    .clk(clk), .rst(rst), .load_start(ls[0]), .byte_valid(bv[0]),
    .byte_data(bd[0]), .byte_last(bl[0]), .byte_ready(rdy[0]),
    .ram_we(we[0]), .ram_addr(addr[0]), .ram_data(data[0]),
    .pc_recount(pc[0]), .cpu_hold(hold[0]), .load_done(done[0]),
    .byte_count(bc[0]), .overflow_err(ovf[0])
  );

  program_loader #(.DATA_W(8), .ADDR_W(4), .DEPTH(16), .CLEAR_EN(1)) u1 (
    .clk(clk), .rst(rst), .load_start(ls[1]), .byte_valid(bv[1]),
    .byte_data(bd[1]), .byte_last(bl[1]), .byte_ready(rdy[1]),
    .ram_we(we[1]), .ram_addr(addr[1]), .ram_data(data[1]),
    .pc_recount(pc[1]), .cpu_hold(hold[1]), .load_done(done[1]),
    .byte_count(bc[1]), .overflow_err(ovf[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nt = 0;
  int nf = 0;
  int cyc = 0;
  int wa [2][64];
  int wd [2][64];
  int wc [2][64];
  int wn [2];
  int pcn [2];
  int pcc [2];
  int fall [2];
  bit hprev [2];
  int prog [32];
  int acc [32];

  // Monitor: log every RAM write and the PC/hold events per instance
  always @(negedge clk) begin
    cyc = cyc + 1;
    for (int k = 0; k < 2; k++) begin
      if (we[k] && wn[k] < 64) begin
        wa[k][wn[k]] = int'(addr[k]);
        wd[k][wn[k]] = int'(data[k]);
        wc[k][wn[k]] = cyc;
        wn[k] = wn[k] + 1;
      end
      if (pc[k]) begin
        pcn[k] = pcn[k] + 1;
        pcc[k] = cyc;
      end
      if (hprev[k] && !hold[k]) fall[k] = cyc;
      hprev[k] = hold[k];
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    nt++;
    if (act != exp) begin
      nf++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic clear_log(input int k);
    wn[k] = 0;
    pcn[k] = 0;
    pcc[k] = -1;
    fall[k] = -1;
  endtask

  task automatic start_load(input int k);
    clear_log(k);
    @(negedge clk);
    ls[k] = 1'b1;
    @(negedge clk);
    ls[k] = 1'b0;
    chk("start_hold", int'(hold[k]), 1);
    chk("start_done", int'(done[k]), 0);
    chk("start_ovf", int'(ovf[k]), 0);
    chk("start_count", int'(bc[k]), 0);
  endtask

  task automatic send_bytes(input int k, input int n, input bit last,
                            input int gap, input bit mid);
    int  i = 0;
    int  budget = 0;
    bit  pend = 0;
    bit  mid_done = 0;
    bit  r;
    while (i < n && budget < 400) begin
      @(negedge clk);
      budget++;
      ls[k] = 1'b0;
      if (mid && i == 1 && !mid_done) begin
        ls[k] = 1'b1;
        mid_done = 1;
      end
      if (!pend) begin
        if (gap > 0 && $urandom_range(99) < gap) begin
          bv[k] = 1'b0;
        end else begin
          bv[k] = 1'b1;
          bd[k] = 8'(prog[i]);
          bl[k] = last && (i == n - 1);
          pend = 1;
        end
      end
      r = rdy[k];
      @(posedge clk);
      if (bv[k] && r) begin
        acc[i] = cyc;
        i++;
        pend = 0;
      end
    end
    @(negedge clk);
    bv[k] = 1'b0;
    bl[k] = 1'b0;
    ls[k] = 1'b0;
    chk("send_timeout", i, n);
  endtask

  task automatic check_load(input int k, input int n, input bit clr,
                            input int ecnt, input bit eovf);
    int off;
    int lim;
    bit ok;
    repeat (6) @(negedge clk);
    off = clr ? 16 : 0;
    chk("nwrites", wn[k], off + n);
    if (clr) begin
      ok = (wn[k] >= 16);
      for (int j = 0; j < 16 && j < wn[k]; j++)
        if (wa[k][j] != j || wd[k][j] != 0 || wc[k][j] != wc[k][0] + j) ok = 0;
      chk("clear_seq", int'(ok), 1);
    end
    ok = 1;
    lim = (wn[k] - off < n) ? wn[k] - off : n;
    for (int i = 0; i < lim; i++)
      if (wa[k][off+i] != i || wd[k][off+i] != prog[i] ||
          wc[k][off+i] != acc[i] + 1) ok = 0;
    chk("write_seq", int'(ok), 1);
    chk("pc_pulses", pcn[k], 1);
    if (wn[k] > 0) chk("pc_timing", pcc[k], wc[k][wn[k]-1] + 1);
    chk("hold_timing", fall[k], pcc[k] + 1);
    chk("byte_count", int'(bc[k]), ecnt);
    chk("load_done", int'(done[k]), 1);
    chk("overflow", int'(ovf[k]), int'(eovf));
    chk("run_hold", int'(hold[k]), 0);
    chk("run_ready", int'(rdy[k]), 0);
    chk("run_we", int'(we[k]), 0);
  endtask

  typedef struct {
    int k;
    int n;
    bit last;
    int gap;
    bit mid;
    int ecnt;
    bit eovf;
  } vec_t;

  vec_t tbl [7];

  initial begin
    tbl[0] = '{k: 1, n: 2,  last: 1, gap: 0,  mid: 0, ecnt: 2,  eovf: 0};
    tbl[1] = '{k: 0, n: 16, last: 0, gap: 0,  mid: 0, ecnt: 16, eovf: 1};
    tbl[2] = '{k: 0, n: 6,  last: 1, gap: 50, mid: 0, ecnt: 6,  eovf: 0};
    tbl[3] = '{k: 0, n: 5,  last: 1, gap: 30, mid: 1, ecnt: 5,  eovf: 0};
    tbl[4] = '{k: 1, n: 16, last: 1, gap: 40, mid: 0, ecnt: 16, eovf: 0};
    tbl[5] = '{k: 0, n: 1,  last: 1, gap: 0,  mid: 0, ecnt: 1,  eovf: 0};
    tbl[6] = '{k: 1, n: 16, last: 0, gap: 20, mid: 0, ecnt: 16, eovf: 1};

    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      ls[k] = 1'b0;
      bv[k] = 1'b0;
      bl[k] = 1'b0;
      bd[k] = 8'h00;
      wn[k] = 0;
      hprev[k] = 1'b1;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_hold", int'(hold[k]), 1);
      chk("rst_ready", int'(rdy[k]), 0);
      chk("rst_we", int'(we[k]), 0);
      chk("rst_pc", int'(pc[k]), 0);
      chk("rst_done", int'(done[k]), 0);
      chk("rst_count", int'(bc[k]), 0);
      chk("rst_ovf", int'(ovf[k]), 0);
    end
    rst = 1'b1;

    prog[0] = 'hA1;
    prog[1] = 'hB2;
    prog[2] = 'hC3;
    start_load(0);
    send_bytes(0, 3, 1'b1, 0, 1'b0);
    check_load(0, 3, 1'b0, 3, 1'b0);

    for (int t = 0; t < 7; t++) begin
      for (int i = 0; i < 32; i++) prog[i] = int'($urandom_range(255));
      start_load(tbl[t].k);
      send_bytes(tbl[t].k, tbl[t].n, tbl[t].last, tbl[t].gap, tbl[t].mid);
      check_load(tbl[t].k, tbl[t].n, tbl[t].k == 1,
                 tbl[t].ecnt, tbl[t].eovf);
    end

    // Abort a load after two bytes with an asynchronous reset
    for (int i = 0; i < 32; i++) prog[i] = int'($urandom_range(255));
    start_load(0);
    send_bytes(0, 2, 1'b0, 0, 1'b0);
    chk("abort_inload", int'(rdy[0]), 1);
    rst = 1'b0;
    #1;
    chk("abort_hold", int'(hold[0]), 1);
    chk("abort_ready", int'(rdy[0]), 0);
    chk("abort_we", int'(we[0]), 0);
    chk("abort_count", int'(bc[0]), 0);
    chk("abort_done", int'(done[0]), 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 32; i++) prog[i] = int'($urandom_range(255));
    start_load(0);
    send_bytes(0, 4, 1'b1, 25, 1'b0);
    check_load(0, 4, 1'b0, 4, 1'b0);

    $display("[TB] %0d tests run, %0d failed", nt, nf);
    $finish;
  end

endmodule
